// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch controller: FSM states, PC source selects and counter width.
package fetch_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_BOOT = 3'd1,
    ST_RUN  = 3'd2,
    ST_HALT = 3'd3
  } state_t;

  localparam logic [1:0] SEL_INIT   = 2'b00;
  localparam logic [1:0] SEL_NEXT   = 2'b01;
  localparam logic [1:0] SEL_BRANCH = 2'b10;
  localparam logic [1:0] SEL_ZERO   = 2'b11;

endpackage

// File: rtl/fetch_ctrl_event_counter.sv
// Free-running wrap-around event counter with increment enable and async reset.
module event_counter
  import fetch_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: picks the PC source, gates the PC load and qualifies the fetched instruction.
module fetch_ctrl
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             branch_req,
  input  logic             trap_req,
  input  logic             halt,
  output logic [1:0]       sel_pc,
  output logic             enable_pc,
  output logic             inst_valid,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] redirect_count
);

  // inst_valid/stall form a valid/ready pair toward decode: an instruction is
  // accepted on a cycle where inst_valid=1 and stall=0; inst_valid never depends on stall.
  state_t state_q, state_d;
  logic   redirect;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = ST_IDLE;
    sel_pc     = SEL_INIT;
    enable_pc  = 1'b0;
    inst_valid = 1'b0;
    redirect   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = start ? ST_BOOT : ST_IDLE;
      end
      ST_BOOT: begin
        enable_pc = 1'b1;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        state_d = ST_RUN;
        // Redirects win over stall: the PC loads and the current word is squashed.
        if (trap_req) begin
          sel_pc    = SEL_ZERO;
          enable_pc = 1'b1;
          redirect  = 1'b1;
        end else if (branch_req) begin
          sel_pc    = SEL_BRANCH;
          enable_pc = 1'b1;
          redirect  = 1'b1;
        end else if (halt) begin
          sel_pc  = SEL_NEXT;
          state_d = ST_HALT;
        end else begin
          sel_pc     = SEL_NEXT;
          inst_valid = 1'b1;
          enable_pc  = ~stall;
        end
      end
      ST_HALT: begin
        sel_pc  = SEL_NEXT;
        state_d = ST_HALT;
        if (trap_req) begin
          sel_pc    = SEL_ZERO;
          enable_pc = 1'b1;
          redirect  = 1'b1;
          state_d   = ST_RUN;
        end else if (start) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign state = state_q;

  event_counter #(.W(CNT_W)) u_fetch_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (inst_valid & ~stall),
    .count (fetch_count)
  );

  event_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (redirect),
    .count (redirect_count)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed and random cycles checked against a rule-level reference model.
module tb_fetch_ctrl;

  localparam logic [15:0] INIT_ADDR = 16'h0100;
  localparam int M_IDLE = 0;
  localparam int M_BOOT = 1;
  localparam int M_RUN  = 2;
  localparam int M_HALT = 3;

  typedef struct {
    logic [1:0] sel;
    logic       en;
    logic       valid;
    int         nxt;
    logic       redir;
    logic       acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, start, stall, branch_req, trap_req, halt;
  logic [1:0]  sel_pc;
  logic        enable_pc, inst_valid;
  logic [2:0]  state;
  logic [15:0] fetch_count, redirect_count;
  logic [15:0] branch_pc = 16'h0;
  logic [15:0] pc = INIT_ADDR;

  int          m_mode;
  logic [15:0] m_fetch, m_redir, m_pc;
  logic [15:0] exp_q[$];
  int          total = 0;
  int          bad = 0;

  // clock/reset block
  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .stall          (stall),
    .branch_req     (branch_req),
    .trap_req       (trap_req),
    .halt           (halt),
    .sel_pc         (sel_pc),
    .enable_pc      (enable_pc),
    .inst_valid     (inst_valid),
    .state          (state),
    .fetch_count    (fetch_count),
    .redirect_count (redirect_count)
  );

  function automatic logic [15:0] pc_after(logic [1:0] sel, logic [15:0] cur, logic [15:0] bp);
    case (sel)
      2'b00:   return INIT_ADDR;
      2'b01:   return cur + 16'd1;
      2'b10:   return bp;
      default: return 16'h0000;
    endcase
  endfunction

  // The fetch stage's PC register, steered only by the controller outputs.
  always @(posedge clk) begin
    if (enable_pc) pc <= pc_after(sel_pc, pc, branch_pc);
  end

  // Reference model: the controller's rules written as a priority list per mode.
  function automatic exp_t predict(int mode, logic s, logic st, logic br, logic tr, logic h);
    exp_t p;
    p.sel = 2'b00; p.en = 1'b0; p.valid = 1'b0; p.nxt = M_IDLE; p.redir = 1'b0;
    if (mode == M_IDLE) begin
      p.nxt = s ? M_BOOT : M_IDLE;
    end else if (mode == M_BOOT) begin
      p.en = 1'b1; p.nxt = M_RUN;
    end else if (mode == M_RUN) begin
      p.nxt = M_RUN;
      if (tr)      begin p.sel = 2'b11; p.en = 1'b1; p.redir = 1'b1; end
      else if (br) begin p.sel = 2'b10; p.en = 1'b1; p.redir = 1'b1; end
      else if (h)  begin p.sel = 2'b01; p.nxt = M_HALT; end
      else         begin p.sel = 2'b01; p.valid = 1'b1; p.en = !st; end
    end else begin
      p.sel = 2'b01; p.nxt = M_HALT;
      if (tr)     begin p.sel = 2'b11; p.en = 1'b1; p.redir = 1'b1; p.nxt = M_RUN; end
      else if (s) p.nxt = M_RUN;
    end
    p.acc = p.valid && !st;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: one clock cycle with the given inputs, checked at the falling edge.
  task automatic step(input logic s, input logic st, input logic br, input logic tr, input logic h);
    exp_t        p;
    logic [15:0] nxt_pc;
    logic [15:0] got;
    start = s; stall = st; branch_req = br; trap_req = tr; halt = h;
    branch_pc = 16'($urandom);
    @(negedge clk);
    p = predict(m_mode, s, st, br, tr, h);
    chk("state", 32'(state), 32'(m_mode));
    chk("sel_pc", 32'(sel_pc), 32'(p.sel));
    chk("enable_pc", 32'(enable_pc), 32'(p.en));
    chk("inst_valid", 32'(inst_valid), 32'(p.valid));
    chk("fetch_count", 32'(fetch_count), 32'(m_fetch));
    chk("redirect_count", 32'(redirect_count), 32'(m_redir));
    chk("pc", 32'(pc), 32'(m_pc));
    if (p.acc) exp_q.push_back(m_pc);
    if (inst_valid && !stall) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        got = exp_q.pop_front();
        chk("sb_pc", 32'(pc), 32'(got));
      end
    end
    nxt_pc = p.en ? pc_after(p.sel, m_pc, branch_pc) : m_pc;
    @(posedge clk);
    #1;
    m_mode = p.nxt;
    if (p.acc) m_fetch = m_fetch + 16'd1;
    if (p.redir) m_redir = m_redir + 16'd1;
    m_pc = nxt_pc;
  endtask

  // Asynchronous reset asserted mid-cycle, optionally during a branch redirect.
  task automatic mid_reset(input logic br);
    start = 1'b0; stall = 1'b0; trap_req = 1'b0; halt = 1'b0; branch_req = br;
    #2 reset = 1'b1;
    #1;
    chk("rst_state", 32'(state), 32'(M_IDLE));
    chk("rst_fetch", 32'(fetch_count), 32'd0);
    chk("rst_redir", 32'(redirect_count), 32'd0);
    chk("rst_en", 32'(enable_pc), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_sel", 32'(sel_pc), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    branch_req = 1'b0;
    m_mode = M_IDLE; m_fetch = 16'd0; m_redir = 16'd0;
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; stall = 1'b1; branch_req = 1'b1; trap_req = 1'b1; halt = 1'b1;
    m_mode = M_IDLE; m_fetch = 16'd0; m_redir = 16'd0; m_pc = INIT_ADDR;
    @(negedge clk);
    chk("reset_state", 32'(state), 32'(M_IDLE));
    chk("reset_sel", 32'(sel_pc), 32'd0);
    chk("reset_en", 32'(enable_pc), 32'd0);
    chk("reset_valid", 32'(inst_valid), 32'd0);
    chk("reset_fetch", 32'(fetch_count), 32'd0);
    chk("reset_redir", 32'(redirect_count), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // idle ignores everything but start; boot ignores redirects, halt and stall
    step(0, 1, 1, 1, 1);
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0);
    chk("boot_pc", 32'(pc), 32'(INIT_ADDR + 16'd1));

    // ten plain fetches
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
    chk("ten_fetch", 32'(fetch_count), 32'd11);
    chk("ten_pc", 32'(pc), 32'(INIT_ADDR + 16'd11));

    // stall window with a branch in the middle
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("branch_redir", 32'(redirect_count), 32'd1);
    step(0, 0, 0, 0, 0);

    // trap and branch together: trap wins
    step(0, 0, 1, 1, 0);
    chk("trap_pc", 32'(pc), 32'd0);
    step(0, 0, 0, 0, 0);

    // halt, branch ignored, resume at the held PC
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // trap in halt beats start
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);

    // reset during a branch cycle; start needed again
    mid_reset(1'b1);
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
    end

    // fetch counter wrap
    mid_reset(1'b0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 65535; i++) step(0, 0, 0, 0, 0);
    chk("preload_ffff", 32'(fetch_count), 32'h0000ffff);
    step(0, 0, 0, 0, 0);
    chk("wrap_zero", 32'(fetch_count), 32'd0);
    step(0, 0, 0, 0, 0);
    mid_reset(1'b0);
    step(0, 0, 0, 0, 0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
